// File: rtl/demux2_stream_pkg.sv
// Shared definitions for the two-way stream demultiplexer.
// Holds the destination select encodings and the FIFO operation decode.
package demux2_stream_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifoOp(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/demux2_stream_if.sv
// Stream bundle between one producer, the demux, and the two consumers A and B.
// The master side is the producer/consumer environment; the slave side is the demux.
interface demux2_stream_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic [LW-1:0]    a_level;

  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic [LW-1:0]    b_level;

  modport master (
    output in_valid, in_sel, in_data, a_ready, b_ready,
    input  in_ready, a_valid, a_data, a_level, b_valid, b_data, b_level
  );

  modport slave (
    input  in_valid, in_sel, in_data, a_ready, b_ready,
    output in_ready, a_valid, a_data, a_level, b_valid, b_data, b_level
  );

endinterface

// File: rtl/demux2_stream_fifo.sv
// Small synchronous FIFO used as the per-destination queue of the demux.
// Push is ignored when full and pop when empty, so level stays within 0..DEPTH.
module demux_fifo
  import demux2_stream_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 2,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case (fifoOp(w_push, w_pop))
        FIFO_PUSH: r_level <= r_level + LW'(1);
        FIFO_POP:  r_level <= r_level - LW'(1);
        default:   r_level <= r_level;
      endcase
    end
  end

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/demux2_stream.sv
// Routes each input word to FIFO A or B by its select bit; each FIFO feeds its own consumer.
// in_ready looks only at the selected FIFO's fullness, never at the consumer readies.
module demux2_stream
  import demux2_stream_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 2,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux2_stream_if.slave       bus
);

  logic             w_full_a;
  logic             w_full_b;
  logic             w_empty_a;
  logic             w_empty_b;
  logic             w_in_ready;
  logic             w_push_a;
  logic             w_push_b;
  logic             w_pop_a;
  logic             w_pop_b;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic [LW-1:0]    w_level_a;
  logic [LW-1:0]    w_level_b;

  assign w_in_ready = (bus.in_sel == SEL_A) ? ~w_full_a : ~w_full_b;
  assign w_push_a   = bus.in_valid & w_in_ready & (bus.in_sel == SEL_A);
  assign w_push_b   = bus.in_valid & w_in_ready & (bus.in_sel == SEL_B);
  assign w_pop_a    = ~w_empty_a & bus.a_ready;
  assign w_pop_b    = ~w_empty_b & bus.b_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push_a),
    .i_push_data (bus.in_data),
    .o_full      (w_full_a),
    .i_pop       (w_pop_a),
    .o_head      (w_head_a),
    .o_empty     (w_empty_a),
    .o_level     (w_level_a)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push_b),
    .i_push_data (bus.in_data),
    .o_full      (w_full_b),
    .i_pop       (w_pop_b),
    .o_head      (w_head_b),
    .o_empty     (w_empty_b),
    .o_level     (w_level_b)
  );

  assign bus.in_ready = w_in_ready;
  assign bus.a_valid  = ~w_empty_a;
  assign bus.a_data   = w_head_a;
  assign bus.a_level  = w_level_a;
  assign bus.b_valid  = ~w_empty_b;
  assign bus.b_data   = w_head_b;
  assign bus.b_level  = w_level_b;

endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: fixed vector table, reset mid-stream, random stress.
// A pair of queues models the two destinations; every cycle the DUT is compared against them.
module tb_demux2_stream;

  localparam int WIDTH = 2;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  demux2_stream_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       s;
    logic [1:0] d;
    logic       ar;
    logic       br;
    logic       exRdy;
    logic       exAv;
    logic [1:0] exAd;
    logic [1:0] exAl;
    logic       exBv;
    logic [1:0] exBd;
    logic [1:0] exBl;
  } vec_t;

  vec_t vecs[$];
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int testsRun = 0;
  int testsFailed = 0;

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic v, s, input logic [1:0] d, input logic ar, br, exRdy, exAv,
                        input logic [1:0] exAd, exAl, input logic exBv, input logic [1:0] exBd, exBl);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.ar = ar; t.br = br; t.exRdy = exRdy;
    t.exAv = exAv; t.exAd = exAd; t.exAl = exAl; t.exBv = exBv; t.exBd = exBd; t.exBl = exBl;
    vecs.push_back(t);
  endtask

  // Drive one cycle's inputs mid-cycle, then settle before any checks.
  task automatic applyStimulus(input logic v, s, input logic [WIDTH-1:0] d, input logic ar, br);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
    bus.a_ready  = ar;
    bus.b_ready  = br;
    #1;
  endtask

  // Compare against the queue model, then advance the model by the coming edge.
  task automatic checkOutput();
    int  selLevel;
    bit  expRdy, popA, popB;
    selLevel = bus.in_sel ? qb.size() : qa.size();
    expRdy   = (selLevel < DEPTH);
    compare("in_ready", 32'(bus.in_ready), 32'(expRdy));
    compare("a_valid", 32'(bus.a_valid), 32'(qa.size() != 0));
    compare("b_valid", 32'(bus.b_valid), 32'(qb.size() != 0));
    compare("a_level", 32'(bus.a_level), 32'(qa.size()));
    compare("b_level", 32'(bus.b_level), 32'(qb.size()));
    if (qa.size() != 0) compare("a_data", 32'(bus.a_data), 32'(qa[0]));
    if (qb.size() != 0) compare("b_data", 32'(bus.b_data), 32'(qb[0]));
    popA = (qa.size() != 0) && (bus.a_ready === 1'b1);
    popB = (qb.size() != 0) && (bus.b_ready === 1'b1);
    if (popA) void'(qa.pop_front());
    if (popB) void'(qb.pop_front());
    if (bus.in_valid === 1'b1 && expRdy) begin
      if (bus.in_sel) qb.push_back(bus.in_data);
      else            qa.push_back(bus.in_data);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    compare("rst a_valid", 32'(bus.a_valid), 32'd0);
    compare("rst b_valid", 32'(bus.b_valid), 32'd0);
    compare("rst a_level", 32'(bus.a_level), 32'd0);
    compare("rst b_level", 32'(bus.b_level), 32'd0);
    compare("rst a_data", 32'(bus.a_data), 32'd0);
    compare("rst b_data", 32'(bus.b_data), 32'd0);
    @(posedge clk);
    #1;
    compare("rst edge a_level", 32'(bus.a_level), 32'd0);
    compare("rst edge b_level", 32'(bus.b_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    compare("post-rst in_ready", 32'(bus.in_ready), 32'd1);
    compare("post-rst a_valid", 32'(bus.a_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    bus.in_data  = '0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;

    //     v  s  d  ar br | rdy aV aD aL bV bD bL
    addVec(1, 0, 3, 1, 1,   1,  0, 0, 0, 0, 0, 0);
    addVec(1, 1, 1, 1, 1,   1,  1, 3, 1, 0, 0, 0);
    addVec(1, 0, 2, 1, 1,   1,  0, 0, 0, 1, 1, 1);
    addVec(0, 0, 0, 1, 1,   1,  1, 2, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 1,   1,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 1, 0, 1,   1,  0, 0, 0, 0, 0, 0);
    addVec(1, 0, 2, 0, 1,   1,  1, 1, 1, 0, 0, 0);
    addVec(1, 0, 3, 0, 1,   0,  1, 1, 2, 0, 0, 0);
    addVec(1, 1, 0, 0, 1,   1,  1, 1, 2, 0, 0, 0);
    addVec(1, 1, 3, 0, 1,   1,  1, 1, 2, 1, 0, 1);
    addVec(1, 0, 0, 1, 1,   0,  1, 1, 2, 1, 3, 1);
    addVec(1, 0, 0, 1, 1,   1,  1, 2, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 1,   1,  1, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 1,   1,  1, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 1,   1,  0, 0, 0, 0, 0, 0);

    resetDut();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].ar, vecs[i].br);
      compare($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exRdy));
      compare($sformatf("vec%0d a_valid", i), 32'(bus.a_valid), 32'(vecs[i].exAv));
      compare($sformatf("vec%0d a_level", i), 32'(bus.a_level), 32'(vecs[i].exAl));
      compare($sformatf("vec%0d b_valid", i), 32'(bus.b_valid), 32'(vecs[i].exBv));
      compare($sformatf("vec%0d b_level", i), 32'(bus.b_level), 32'(vecs[i].exBl));
      if (vecs[i].exAv) compare($sformatf("vec%0d a_data", i), 32'(bus.a_data), 32'(vecs[i].exAd));
      if (vecs[i].exBv) compare($sformatf("vec%0d b_data", i), 32'(bus.b_data), 32'(vecs[i].exBd));
      checkOutput();
    end

    // Fill A with two words, then reset: neither may ever come out.
    applyStimulus(1, 0, 2'b01, 0, 0);
    checkOutput();
    applyStimulus(1, 0, 2'b10, 0, 0);
    checkOutput();
    applyStimulus(0, 0, 2'b00, 0, 0);
    compare("pre-rst a_level", 32'(bus.a_level), 32'd2);
    compare("pre-rst in_ready sel A", 32'(bus.in_ready), 32'd0);
    checkOutput();
    resetDut();
    applyStimulus(1, 0, 2'b11, 0, 1);
    checkOutput();
    applyStimulus(0, 0, 2'b00, 0, 1);
    compare("after rst first a_data", 32'(bus.a_data), 32'd3);
    compare("after rst a_level", 32'(bus.a_level), 32'd1);
    checkOutput();

    for (int c = 0; c < 10000; c++) begin
      applyStimulus(($urandom % 4) != 0, $urandom_range(0, 1), WIDTH'($urandom),
                    ($urandom % 3) != 0, ($urandom % 3) != 0);
      checkOutput();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
